// File: rtl/lab1_imul_prod_accum_pkg.sv
// Shared types and widths for the lab1 product accumulator.
package lab1_imul_prod_accum_pkg;

  localparam int unsigned SUM_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/lab1_imul_prod_accum.sv
// Sums each group of NUM_PRODS multiplier products modulo 2^32 and emits
// one sum per group over a val/rdy stream, with bubble-free group boundaries.
module lab1_imul_prod_accum
  import lab1_imul_prod_accum_pkg::*;
#(
  parameter int unsigned NUM_PRODS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [SUM_W-1:0] istream_msg,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [SUM_W-1:0] ostream_msg
);

  localparam int unsigned CNT_W = $clog2(NUM_PRODS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PRODS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SUM_W-1:0] sum_reg;
  logic [SUM_W-1:0] sum_nxt;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_nxt;
  logic             in_xfer;
  logic             out_xfer;

  // State, running sum and product count; cleared asynchronously on reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACCUM;
      sum_reg   <= '0;
      count_reg <= '0;
    end else begin
      state     <= state_nxt;
      sum_reg   <= sum_nxt;
      count_reg <= count_nxt;
    end
  end

  // Next-state and stream handshake logic.
  always_comb begin
    state_nxt   = state;
    sum_nxt     = sum_reg;
    count_nxt   = count_reg;
    istream_rdy = 1'b1;
    ostream_val = 1'b0;
    ostream_msg = '0;
    in_xfer     = 1'b0;
    out_xfer    = 1'b0;

    case (state)
      ACCUM: begin
        in_xfer = istream_val;
        if (in_xfer) begin
          sum_nxt = sum_reg + istream_msg;
          if (count_reg == LAST_CNT) begin
            state_nxt = DONE;
            count_nxt = '0;
          end else begin
            count_nxt = count_reg + CNT_W'(1);
          end
        end
      end

      DONE: begin
        ostream_val = 1'b1;
        ostream_msg = sum_reg;
        istream_rdy = ostream_rdy;
        out_xfer    = ostream_rdy;
        in_xfer     = ostream_rdy && istream_val;
        // A product arriving as the sum leaves seeds the next group.
        if (in_xfer) begin
          sum_nxt = istream_msg;
          if (NUM_PRODS == 1) begin
            count_nxt = '0;
          end else begin
            state_nxt = ACCUM;
            count_nxt = CNT_W'(1);
          end
        end else if (out_xfer) begin
          state_nxt = ACCUM;
          sum_nxt   = '0;
        end
      end

      default: state_nxt = ACCUM;
    endcase
  end

`ifndef SYNTHESIS
  function automatic string line_trace();
    return $sformatf("%b/%b/%h (%s %0d) %b/%b/%h",
                     istream_val, istream_rdy, istream_msg,
                     (state == DONE) ? "D" : "A", count_reg,
                     ostream_val, ostream_rdy, ostream_msg);
  endfunction
`endif

endmodule

// File: tb/tb_lab1_imul_prod_accum.sv
// Scoreboard bench for lab1_imul_prod_accum with NUM_PRODS=4 and NUM_PRODS=1.
module tb_lab1_imul_prod_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        in4_val, in4_rdy, out4_val, out4_rdy;
  logic [31:0] in4_msg, out4_msg;
  logic        in1_val, in1_rdy, out1_val, out1_rdy;
  logic [31:0] in1_msg, out1_msg;

  logic [31:0] exp4_q[$];
  logic [31:0] exp1_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stalls4 = 0;

  always #5 clk = ~clk;

  lab1_imul_prod_accum #(.NUM_PRODS(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .istream_val(in4_val), .istream_rdy(in4_rdy), .istream_msg(in4_msg),
    .ostream_val(out4_val), .ostream_rdy(out4_rdy), .ostream_msg(out4_msg)
  );

  lab1_imul_prod_accum #(.NUM_PRODS(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .istream_val(in1_val), .istream_rdy(in1_rdy), .istream_msg(in1_msg),
    .ostream_val(out1_val), .ostream_rdy(out1_rdy), .ostream_msg(out1_msg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one product and hold it until accepted; returns at posedge+1.
  task automatic put4(input logic [31:0] m);
    int n = 0;
    in4_val = 1'b1;
    in4_msg = m;
    @(negedge clk);
    while (!in4_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls4 += n;
    if (!in4_rdy) check("put4_timeout", 32'(in4_rdy), 32'd1);
    @(posedge clk);
    #1;
    in4_val = 1'b0;
  endtask

  task automatic put1(input logic [31:0] m);
    int n = 0;
    in1_val = 1'b1;
    in1_msg = m;
    @(negedge clk);
    while (!in1_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in1_rdy) check("put1_timeout", 32'(in1_rdy), 32'd1);
    @(posedge clk);
    #1;
    in1_val = 1'b0;
  endtask

  // Reference sum computed by the bench, queued before the group is driven.
  task automatic group4(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    logic [31:0] s;
    s = a + b + c + d;
    exp4_q.push_back(s);
    put4(a);
    put4(b);
    put4(c);
    put4(d);
  endtask

  task automatic idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && out4_val && out4_rdy) begin
      if (exp4_q.size() == 0) check("dut4_underflow", 32'(exp4_q.size()), 32'd1);
      else check("dut4_sum", out4_msg, exp4_q.pop_front());
    end
    if (reset && out1_val && out1_rdy) begin
      if (exp1_q.size() == 0) check("dut1_underflow", 32'(exp1_q.size()), 32'd1);
      else check("dut1_sum", out1_msg, exp1_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    in4_val  = 1'b0; in4_msg = '0; out4_rdy = 1'b1;
    in1_val  = 1'b0; in1_msg = '0; out1_rdy = 1'b1;

    // Reset state, before any clock edge.
    #3;
    check("rst_in4_rdy", 32'(in4_rdy), 32'd1);
    check("rst_out4_val", 32'(out4_val), 32'd0);
    check("rst_out4_msg", out4_msg, 32'd0);
    check("rst_in1_rdy", 32'(in1_rdy), 32'd1);
    check("rst_out1_val", 32'(out1_val), 32'd0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic group and one-cycle output.
    group4(32'd1, 32'd2, 32'd3, 32'd4);
    check("t1_val_rise", 32'(out4_val), 32'd1);
    check("t1_msg", out4_msg, 32'h0000000a);
    @(posedge clk);
    #1;
    check("t1_val_fall", 32'(out4_val), 32'd0);
    idle();

    // Wrap-around and signed sums.
    group4(32'hffffffff, 32'h2, 32'h0, 32'h0);
    idle();
    group4(-32'sd3, 32'sd5, -32'sd7, 32'sd1);
    check("t2_signed_msg", out4_msg, 32'hfffffffc);
    idle();

    // Back-to-back groups without input stalls.
    stalls4 = 0;
    group4(32'd1, 32'd2, 32'd3, 32'd4);
    check("t3_rdy_in_done", 32'(in4_rdy), 32'd1);
    check("t3_val_in_done", 32'(out4_val), 32'd1);
    group4(32'd5, 32'd6, 32'd7, 32'd8);
    check("t3_no_stall", 32'(stalls4), 32'd0);
    idle();

    // Backpressure holds the sum and blocks input.
    out4_rdy = 1'b0;
    group4(32'd2, 32'd2, 32'd2, 32'd2);
    in4_val = 1'b1;
    in4_msg = 32'h55;
    repeat (5) begin
      @(negedge clk);
      check("t4_val_held", 32'(out4_val), 32'd1);
      check("t4_msg_held", out4_msg, 32'd8);
      check("t4_in_blocked", 32'(in4_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    in4_val  = 1'b0;
    out4_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("t4_released", 32'(out4_val), 32'd0);
    idle();

    // Reset mid-group discards the partial sum.
    put4(32'd7);
    put4(32'd9);
    reset = 1'b0;
    #2;
    check("t5_rst_val", 32'(out4_val), 32'd0);
    check("t5_rst_msg", out4_msg, 32'd0);
    check("t5_rst_rdy", 32'(in4_rdy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    group4(32'd1, 32'd1, 32'd1, 32'd1);
    check("t5_msg", out4_msg, 32'd4);
    idle();

    // NUM_PRODS=1: one sum per product, state stays DONE.
    exp1_q.push_back(32'h10);
    exp1_q.push_back(32'h20);
    exp1_q.push_back(32'h30);
    put1(32'h10);
    check("t6_val_a", 32'(out1_val), 32'd1);
    put1(32'h20);
    check("t6_val_b", 32'(out1_val), 32'd1);
    check("t6_msg_b", out1_msg, 32'h20);
    put1(32'h30);
    check("t6_val_c", 32'(out1_val), 32'd1);
    @(posedge clk);
    #1;
    check("t6_val_fall", 32'(out1_val), 32'd0);
    idle();

    check("dut4_drain", 32'(exp4_q.size()), 32'd0);
    check("dut1_drain", 32'(exp1_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
